// File: rtl/matrix_readback_seq_if.sv
// Handshake bundle for the matrix read-back sequencer.
// Ports: master = sequencer side, slave = coprocessor/host side.
interface matrix_readback_seq_if;
   logic        start;
   logic [1:0]  mat_sel;
   logic        busy;
   logic        done;
   logic [21:0] instr;
   logic        instr_valid;
   logic        instr_ready;
   logic        rd_valid;
   logic [7:0]  rd_data;
   logic [7:0]  out_data;
   logic [2:0]  out_row;
   logic [2:0]  out_col;
   logic        out_valid;
   logic        out_ready;
   logic        err;

   modport master (
      input  start, mat_sel,
      input  instr_ready, rd_valid, rd_data,
      input  out_ready,
      output busy, done, err,
      output instr, instr_valid,
      output out_data, out_row, out_col, out_valid
   );

   modport slave (
      output start, mat_sel,
      output instr_ready, rd_valid, rd_data,
      output out_ready,
      input  busy, done, err,
      input  instr, instr_valid,
      input  out_data, out_row, out_col, out_valid
   );
endinterface

// File: rtl/matrix_readback_seq.sv
// Read-side initiator: issues one LOAD per matrix element (row-major),
// waits for read data and streams each element out with row/col tags.
// Ports: clk, rst (async active-high), bus (matrix_readback_seq_if.master):
//   start/mat_sel request, busy/done status, instr/instr_valid/instr_ready
//   to the coprocessor, rd_valid/rd_data back, out_* stream, err flag.
// Optional macro READBACK_TIMEOUT_EN adds a WAIT timeout (param TIMEOUT)
// that sets sticky err and aborts the run; otherwise err is tied 0.
module matrix_readback_seq #(
   parameter int          N       = 5,
   parameter logic [3:0]  LOAD_OP = 4'b0001,
   parameter logic [1:0]  MODE    = 2'b10
`ifdef READBACK_TIMEOUT_EN
   ,
   parameter int          TIMEOUT = 255
`endif
) (
   input  logic                  clk,
   input  logic                  rst,
   matrix_readback_seq_if.master bus
);

   localparam logic [2:0] LAST = 3'(N - 1);

   typedef enum logic [2:0] {
      IDLE,
      ISSUE,
      WAIT,
      OUT,
      DONE
   } state_t;

   state_t      state;
   state_t      state_nx;

   logic [2:0]  row;
   logic [2:0]  col;
   logic [1:0]  sel_q;
   logic [7:0]  data_q;
   logic [2:0]  row_q;
   logic [2:0]  col_q;

   logic        busy_c;
   logic        done_c;
   logic        ivalid_c;
   logic        ovalid_c;
   logic [21:0] instr_c;

   logic        start_acc;
   logic        issue_acc;
   logic        rd_hit;
   logic        out_acc;
   logic        last_col;
   logic        last_row;
   logic        tmo;

   assign start_acc = (state == IDLE) && bus.start;
   assign issue_acc = (state == ISSUE) && bus.instr_ready;
   assign rd_hit    = (state == WAIT) && bus.rd_valid;
   assign out_acc   = (state == OUT) && bus.out_ready;
   assign last_col  = (col == LAST);
   assign last_row  = (row == LAST);

`ifdef READBACK_TIMEOUT_EN
   logic [15:0] tcnt;
   logic        err_q;

   // tcnt holds the number of completed WAIT cycles; abort fires at the
   // end of the TIMEOUT-th WAIT cycle if no data showed up.
   assign tmo = (state == WAIT) && !bus.rd_valid
              && (tcnt == 16'(TIMEOUT - 1));

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         tcnt  <= '0;
         err_q <= 1'b0;
      end else begin
         if (issue_acc)
            tcnt <= '0;
         else if (state == WAIT)
            tcnt <= tcnt + 16'd1;

         if (start_acc)
            err_q <= 1'b0;
         else if (tmo)
            err_q <= 1'b1;
      end
   end

   assign bus.err = err_q;
`else
   assign tmo     = 1'b0;
   assign bus.err = 1'b0;
`endif

   always_ff @(posedge clk or posedge rst) begin
      if (rst)
         state <= IDLE;
      else
         state <= state_nx;
   end

   always_comb begin
      state_nx = state;
      busy_c   = 1'b1;
      done_c   = 1'b0;
      ivalid_c = 1'b0;
      ovalid_c = 1'b0;
      instr_c  = '0;
      unique case (state)
         IDLE: begin
            busy_c = 1'b0;
            if (bus.start)
               state_nx = ISSUE;
         end
         ISSUE: begin
            ivalid_c = 1'b1;
            instr_c  = {MODE, 8'h00, sel_q, row, col, LOAD_OP};
            if (bus.instr_ready)
               state_nx = WAIT;
         end
         WAIT: begin
            if (bus.rd_valid)
               state_nx = OUT;
            else if (tmo)
               state_nx = DONE;
         end
         OUT: begin
            ovalid_c = 1'b1;
            if (bus.out_ready) begin
               if (last_col && last_row)
                  state_nx = DONE;
               else
                  state_nx = ISSUE;
            end
         end
         DONE: begin
            done_c   = 1'b1;
            state_nx = IDLE;
         end
         default: begin
            busy_c   = 1'b0;
            state_nx = IDLE;
         end
      endcase
   end

   // Element walk, latched matrix select and captured output beat.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         row    <= '0;
         col    <= '0;
         sel_q  <= '0;
         data_q <= '0;
         row_q  <= '0;
         col_q  <= '0;
      end else begin
         if (start_acc) begin
            sel_q <= bus.mat_sel;
            row   <= '0;
            col   <= '0;
         end

         if (rd_hit) begin
            data_q <= bus.rd_data;
            row_q  <= row;
            col_q  <= col;
         end

         if (out_acc) begin
            if (!last_col) begin
               col <= col + 3'd1;
            end else if (!last_row) begin
               col <= '0;
               row <= row + 3'd1;
            end
         end

         if (state == DONE) begin
            row <= '0;
            col <= '0;
         end
      end
   end

   assign bus.busy        = busy_c;
   assign bus.done        = done_c;
   assign bus.instr_valid = ivalid_c;
   assign bus.instr       = instr_c;
   assign bus.out_valid   = ovalid_c;
   assign bus.out_data    = data_q;
   assign bus.out_row     = row_q;
   assign bus.out_col     = col_q;

endmodule

// File: tb/tb_matrix_readback_seq.sv
// Directed bench for matrix_readback_seq (N=5).
// Drives/samples on falling edges; checks with immediate assertions.
module tb_matrix_readback_seq;

   logic       clk = 1'b0;
   logic       rst;
   int         total = 0;
   int         bad = 0;
   int         done_cnt = 0;
   int         beats = 0;
   logic [7:0] last_out;

   matrix_readback_seq_if bus();

   matrix_readback_seq #(
      .N(5)
`ifdef READBACK_TIMEOUT_EN
      ,
      .TIMEOUT(20)
`endif
   ) dut (
      .clk(clk),
      .rst(rst),
      .bus(bus)
   );

   always #5 clk = ~clk;

   always @(posedge clk) begin
      if (bus.done)
         done_cnt <= done_cnt + 1;
      if (bus.out_valid && bus.out_ready)
         beats <= beats + 1;
   end

   initial begin
      #300000;
      $display("FAIL watchdog observed=timeout expected=finish");
      $fatal(1, "watchdog");
   end

   task automatic chk(input string tag, input logic [31:0] obs,
                      input logic [31:0] exp);
      total++;
      assert (obs === exp) else begin
         bad++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   function automatic logic [21:0] ins(input logic [1:0] s,
                                       input int r, input int c);
      logic [2:0] r3;
      logic [2:0] c3;
      r3 = r[2:0];
      c3 = c[2:0];
      return {2'b10, 8'h00, s, r3, c3, 4'b0001};
   endfunction

   task automatic go(input logic [1:0] s);
      @(negedge clk);
      bus.mat_sel = s;
      bus.start   = 1'b1;
      chk("busy_pre_start", 32'(bus.busy), 32'd0);
      @(negedge clk);
      bus.start = 1'b0;
      chk("busy_after_start", 32'(bus.busy), 32'd1);
   endtask

   task automatic wait_issue();
      int k;
      k = 0;
      while (!bus.instr_valid && k < 20) begin
         @(negedge clk);
         k++;
      end
   endtask

   // One element: issue, optional instr stall with spurious read data,
   // read data two cycles after accept, optional output backpressure.
   task automatic elem(input int r, input int c, input logic [1:0] s,
                       input int istall, input int ohold,
                       input bit poke);
      logic [7:0] d;
      d = 8'((r * 16) + c);
      wait_issue();
      chk("instr_valid", 32'(bus.instr_valid), 32'd1);
      chk("instr", 32'(bus.instr), 32'(ins(s, r, c)));
      chk("busy_run", 32'(bus.busy), 32'd1);
      if (istall > 0) begin
         bus.rd_valid = 1'b1;
         bus.rd_data  = 8'hAA;
         repeat (istall) begin
            @(negedge clk);
            bus.rd_valid = 1'b0;
            chk("stall_instr", 32'({bus.instr_valid, bus.instr}),
                32'({1'b1, ins(s, r, c)}));
            chk("stall_outdata", 32'(bus.out_data), 32'(last_out));
         end
      end
      bus.instr_ready = 1'b1;
      @(negedge clk);
      bus.instr_ready = 1'b0;
      chk("wait_novalid", 32'(bus.instr_valid), 32'd0);
      if (poke) begin
         bus.start   = 1'b1;
         bus.mat_sel = 2'b11;
      end
      @(negedge clk);
      bus.start    = 1'b0;
      bus.rd_valid = 1'b1;
      bus.rd_data  = d;
      @(negedge clk);
      bus.rd_valid = 1'b0;
      chk("out_beat", 32'({bus.out_valid, bus.out_row, bus.out_col,
                           bus.out_data}),
          32'({1'b1, r[2:0], c[2:0], d}));
      repeat (ohold) begin
         @(negedge clk);
         chk("hold_beat", 32'({bus.out_valid, bus.instr_valid,
                               bus.out_row, bus.out_col, bus.out_data}),
             32'({2'b10, r[2:0], c[2:0], d}));
      end
      bus.out_ready = 1'b1;
      @(negedge clk);
      bus.out_ready = 1'b0;
      last_out = d;
   endtask

   task automatic fin();
      chk("done_pulse", 32'({bus.done, bus.busy}), 32'b11);
      @(negedge clk);
      chk("done_clear", 32'({bus.done, bus.busy, bus.instr_valid}),
          32'b000);
   endtask

   int d0;
   int b0;

   initial begin
      rst             = 1'b1;
      bus.start       = 1'b0;
      bus.mat_sel     = 2'b00;
      bus.instr_ready = 1'b0;
      bus.rd_valid    = 1'b0;
      bus.rd_data     = 8'h00;
      bus.out_ready   = 1'b0;
      last_out        = 8'h00;
      @(negedge clk);
      @(negedge clk);
      chk("rst_ctrl", 32'({bus.busy, bus.done, bus.instr_valid,
                           bus.out_valid, bus.err}), 32'd0);
      chk("rst_instr", 32'(bus.instr), 32'd0);
      chk("rst_out", 32'({bus.out_row, bus.out_col, bus.out_data}),
          32'd0);
      rst = 1'b0;

      // reset while waiting on element (2,3)
      go(2'b10);
      for (int i = 0; i < 13; i++)
         elem(i / 5, i % 5, 2'b10, 0, 0, 1'b0);
      wait_issue();
      chk("pre_rst_instr", 32'(bus.instr), 32'(ins(2'b10, 2, 3)));
      bus.instr_ready = 1'b1;
      @(negedge clk);
      bus.instr_ready = 1'b0;
      chk("pre_rst_wait", 32'({bus.busy, bus.instr_valid}), 32'b10);
      #2 rst = 1'b1;
      #1;
      chk("mid_rst_ctrl", 32'({bus.busy, bus.done, bus.instr_valid,
                               bus.out_valid, bus.err}), 32'd0);
      chk("mid_rst_instr", 32'(bus.instr), 32'd0);
      chk("mid_rst_out", 32'({bus.out_row, bus.out_col, bus.out_data}),
          32'd0);
      @(negedge clk);
      rst      = 1'b0;
      last_out = 8'h00;

      // basic run over matrix B
      d0 = done_cnt;
      b0 = beats;
      go(2'b01);
      chk("first_instr", 32'(bus.instr),
          32'(22'b10_00000000_01_000_000_0001));
      for (int i = 0; i < 25; i++)
         elem(i / 5, i % 5, 2'b01, 0, 0, 1'b0);
      chk("last_data", 32'(bus.out_data), 32'h44);
      fin();
      chk("basic_done_cnt", 32'(done_cnt - d0), 32'd1);
      chk("basic_beats", 32'(beats - b0), 32'd25);

      // stall, backpressure and ignored start/mat_sel over matrix C
      d0 = done_cnt;
      go(2'b10);
      for (int i = 0; i < 25; i++)
         elem(i / 5, i % 5, 2'b10,
              (i == 1) ? 5 : 0,
              (i == 7) ? 10 : 0,
              (i == 10));
      fin();
      chk("stress_done_cnt", 32'(done_cnt - d0), 32'd1);

`ifdef READBACK_TIMEOUT_EN
      b0 = beats;
      d0 = done_cnt;
      go(2'b00);
      for (int i = 0; i < 3; i++)
         elem(0, i, 2'b00, 0, 0, 1'b0);
      wait_issue();
      bus.instr_ready = 1'b1;
      @(negedge clk);
      bus.instr_ready = 1'b0;
      repeat (19) @(negedge clk);
      chk("tmo_not_yet", 32'({bus.err, bus.done}), 32'b00);
      @(negedge clk);
      chk("tmo_fire", 32'({bus.err, bus.done}), 32'b11);
      chk("tmo_beats", 32'(beats - b0), 32'd3);
      @(negedge clk);
      chk("tmo_sticky", 32'({bus.err, bus.busy}), 32'b10);
      go(2'b00);
      chk("tmo_clear", 32'(bus.err), 32'd0);
      rst = 1'b1;
      @(negedge clk);
      rst = 1'b0;
`endif

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
